// File: rtl/load_store_unit.sv
// Memory-access stage: one data-memory transaction per load/store over a req/gnt/rvalid
// bus, stalling the pipeline until it completes and returning extended load data.
module load_store_unit #(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_valid,
   input  logic            i_load,
   input  logic            i_store,
   input  logic [2:0]      i_funct3,
   input  logic [XLEN-1:0] i_addr,
   input  logic [XLEN-1:0] i_wdata,
   output logic            o_stall,
   output logic            o_dmem_req,
   output logic            o_dmem_we,
   output logic [3:0]      o_dmem_be,
   output logic [XLEN-1:0] o_dmem_addr,
   output logic [XLEN-1:0] o_dmem_wdata,
   input  logic            i_dmem_gnt,
   input  logic            i_dmem_rvalid,
   input  logic [XLEN-1:0] i_dmem_rdata,
   output logic            o_ldValid,
   output logic [XLEN-1:0] o_ldData,
   output logic            o_misaligned,
   output logic            o_illegal
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   state_t          state_q;
   logic            req_q;
   logic            we_q;
   logic [1:0]      off_q;
   logic [2:0]      f3_q;
   logic [3:0]      be_q;
   logic [XLEN-1:0] addr_q;
   logic [XLEN-1:0] wdata_q;

   logic            op, legal_f3, is_idle, mis_c, ill_c, accept;
   logic [3:0]      be_d;
   logic [XLEN-1:0] wdata_d;
   logic [7:0]      ld_byte;
   logic [15:0]     ld_half;
   logic [XLEN-1:0] ld_ext;

   assign op       = i_valid & (i_load | i_store);
   assign legal_f3 = (i_funct3 == 3'b000) | (i_funct3 == 3'b001) | (i_funct3 == 3'b010) |
                     (i_funct3 == 3'b100) | (i_funct3 == 3'b101);
   // Gating with i_rst_n keeps stall/fault outputs at 0 while reset is held.
   assign is_idle  = (state_q == S_IDLE) & i_rst_n;
   assign mis_c    = op & legal_f3 & (((i_funct3[1:0] == 2'b01) & i_addr[0]) |
                                      ((i_funct3[1:0] == 2'b10) & (i_addr[1:0] != 2'b00)));
   assign ill_c    = op & (~legal_f3 | (i_store & i_funct3[2]) | (i_load & i_store));

   assign o_misaligned = is_idle & mis_c;
   assign o_illegal    = is_idle & ill_c;
   assign accept       = is_idle & op & ~mis_c & ~ill_c;

   always_comb begin
      be_d    = 4'b1111;
      wdata_d = i_wdata;
      case (i_funct3[1:0])
         2'b00: begin
            be_d    = 4'b0001 << i_addr[1:0];
            wdata_d = {4{i_wdata[7:0]}};
         end
         2'b01: begin
            be_d    = 4'b0011 << i_addr[1:0];
            wdata_d = {2{i_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   assign o_stall = accept |
                    ((state_q == S_REQ)  & ~(i_dmem_gnt & we_q)) |
                    ((state_q == S_WAIT) & ~i_dmem_rvalid);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         off_q   <= 2'b00;
         f3_q    <= 3'b000;
         be_q    <= 4'b0000;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  state_q <= S_REQ;
                  req_q   <= 1'b1;
                  we_q    <= i_store;
                  off_q   <= i_addr[1:0];
                  f3_q    <= i_funct3;
                  be_q    <= be_d;
                  addr_q  <= {i_addr[XLEN-1:2], 2'b00};
                  wdata_q <= wdata_d;
               end
            end
            S_REQ: begin
               if (i_dmem_gnt) begin
                  req_q   <= 1'b0;
                  state_q <= we_q ? S_IDLE : S_WAIT;
               end
            end
            S_WAIT: begin
               if (i_dmem_rvalid) state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   assign o_dmem_req   = req_q;
   assign o_dmem_we    = we_q;
   assign o_dmem_be    = be_q;
   assign o_dmem_addr  = addr_q;
   assign o_dmem_wdata = wdata_q;

   always_comb begin
      ld_byte = 8'h00;
      case (off_q)
         2'b00: ld_byte = i_dmem_rdata[7:0];
         2'b01: ld_byte = i_dmem_rdata[15:8];
         2'b10: ld_byte = i_dmem_rdata[23:16];
         2'b11: ld_byte = i_dmem_rdata[31:24];
         default: ;
      endcase
      ld_half = off_q[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
      case (f3_q)
         3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_ext = {24'h000000, ld_byte};
         3'b101:  ld_ext = {16'h0000, ld_half};
         default: ld_ext = i_dmem_rdata;
      endcase
   end

   assign o_ldValid = (state_q == S_WAIT) & i_dmem_rvalid;
   assign o_ldData  = o_ldValid ? ld_ext : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a bus responder plus a scoreboard monitor that
// checks every granted request and every returned load against queued expectations.
module tb_load_store_unit;

   typedef struct packed {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } bus_t;

   logic        i_clk, i_rst_n;
   logic        i_valid, i_load, i_store;
   logic [2:0]  i_funct3;
   logic [31:0] i_addr, i_wdata;
   logic        o_stall, o_dmem_req, o_dmem_we;
   logic [3:0]  o_dmem_be;
   logic [31:0] o_dmem_addr, o_dmem_wdata;
   logic        i_dmem_gnt, i_dmem_rvalid;
   logic [31:0] i_dmem_rdata;
   logic        o_ldValid;
   logic [31:0] o_ldData;
   logic        o_misaligned, o_illegal;

   int total = 0;
   int bad   = 0;

   bus_t        bus_q[$];
   logic [31:0] ld_q[$];

   int          gnt_delay = 0, rv_delay = 0, req_cnt = 0, rv_cnt = 0;
   logic        pending_rv = 1'b0;
   logic [31:0] rdata_cfg = '0;

   load_store_unit #(.XLEN(32)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_load(i_load),
      .i_store(i_store), .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
      .o_stall(o_stall), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
      .o_dmem_be(o_dmem_be), .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata),
      .i_dmem_gnt(i_dmem_gnt), .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata),
      .o_ldValid(o_ldValid), .o_ldData(o_ldData), .o_misaligned(o_misaligned),
      .o_illegal(o_illegal)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", name, act, exp);
      end
   endtask

   // Bus responder: grants after gnt_delay extra REQ cycles, returns rdata rv_delay
   // cycles after the first cycle following the grant.
   initial begin
      i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = '0;
      forever begin
         @(posedge i_clk); #1;
         i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = '0;
         if (pending_rv) begin
            if (rv_cnt == rv_delay) begin
               i_dmem_rvalid = 1'b1; i_dmem_rdata = rdata_cfg; pending_rv = 1'b0;
            end else rv_cnt++;
         end else if (o_dmem_req) begin
            if (req_cnt == gnt_delay) begin
               i_dmem_gnt = 1'b1; req_cnt = 0;
               if (!o_dmem_we) begin pending_rv = 1'b1; rv_cnt = 0; end
            end else req_cnt++;
         end else req_cnt = 0;
      end
   end

   // Scoreboard monitor.
   initial begin
      bus_t e;
      logic [31:0] ld;
      forever begin
         @(negedge i_clk);
         if (i_rst_n && o_dmem_req && i_dmem_gnt) begin
            if (bus_q.size() == 0) chk("unexpected_grant", 32'd1, 32'd0);
            else begin
               e = bus_q.pop_front();
               chk("bus_we", {31'd0, o_dmem_we}, {31'd0, e.we});
               chk("bus_be", {28'd0, o_dmem_be}, {28'd0, e.be});
               chk("bus_addr", o_dmem_addr, e.addr);
               if (e.we) chk("bus_wdata", o_dmem_wdata, e.wdata);
               $display("bus txn we=%0b be=%b addr=%h wdata=%h", o_dmem_we, o_dmem_be,
                        o_dmem_addr, o_dmem_wdata);
            end
         end
         if (o_ldValid) begin
            if (ld_q.size() == 0) chk("unexpected_ldValid", 32'd1, 32'd0);
            else begin
               ld = ld_q.pop_front();
               chk("ld_data", o_ldData, ld);
               $display("load txn data=%h", o_ldData);
            end
         end else chk("ld_data_idle_zero", o_ldData, 32'd0);
      end
   end

   task automatic issue(input string name, input logic ld, input logic st,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                        input int gd, input int rd, input logic [31:0] rdat,
                        input int exp_stall, input logic exp_mis, input logic exp_ill);
      int   nst;
      logic done;
      nst = 0; done = 1'b0;
      gnt_delay = gd; rv_delay = rd; rdata_cfg = rdat;
      i_valid = 1'b1; i_load = ld; i_store = st; i_funct3 = f3; i_addr = a; i_wdata = d;
      for (int c = 0; c < 40; c++) begin
         @(negedge i_clk);
         if (c == 0) begin
            chk({name, "_misaligned"}, {31'd0, o_misaligned}, {31'd0, exp_mis});
            chk({name, "_illegal"}, {31'd0, o_illegal}, {31'd0, exp_ill});
            chk({name, "_no_req_first"}, {31'd0, o_dmem_req}, 32'd0);
         end
         if (o_dmem_req) chk({name, "_req_addr_stable"}, o_dmem_addr, {a[31:2], 2'b00});
         if (o_stall) nst++;
         else begin done = 1'b1; break; end
      end
      if (!done) chk({name, "_timeout"}, 32'd0, 32'd1);
      chk({name, "_stall_cycles"}, nst, exp_stall);
      $display("op %s stall_cycles=%0d", name, nst);
      @(posedge i_clk); #1;
      i_valid = 1'b0; i_load = 1'b0; i_store = 1'b0;
   endtask

   initial begin
      i_rst_n = 1'b0; i_valid = 1'b0; i_load = 1'b0; i_store = 1'b0;
      i_funct3 = 3'b000; i_addr = '0; i_wdata = '0;
      #12;
      chk("rst_req", {31'd0, o_dmem_req}, 32'd0);
      chk("rst_stall", {31'd0, o_stall}, 32'd0);
      chk("rst_outputs", {o_dmem_we, o_dmem_be, o_ldValid, o_misaligned, o_illegal},
          32'd0);
      chk("rst_addr", o_dmem_addr, 32'd0);
      chk("rst_wdata", o_dmem_wdata, 32'd0);
      i_rst_n = 1'b1;
      @(posedge i_clk); #1;

      bus_q.push_back('{1'b1, 4'b1111, 32'h100, 32'hDEADBEEF});
      issue("SW", 0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0, 1, 0, 0);

      bus_q.push_back('{1'b1, 4'b1000, 32'h100, 32'hA5A5A5A5});
      issue("SB", 0, 1, 3'b000, 32'h103, 32'h000000A5, 0, 0, 0, 1, 0, 0);

      bus_q.push_back('{1'b0, 4'b1000, 32'h100, 32'h0});
      ld_q.push_back(32'hFFFFFFA5);
      issue("LB", 1, 0, 3'b000, 32'h103, 0, 0, 0, 32'hA5000000, 2, 0, 0);

      bus_q.push_back('{1'b0, 4'b1000, 32'h100, 32'h0});
      ld_q.push_back(32'h000000A5);
      issue("LBU", 1, 0, 3'b100, 32'h103, 0, 0, 0, 32'hA5000000, 2, 0, 0);

      bus_q.push_back('{1'b0, 4'b1100, 32'h200, 32'h0});
      ld_q.push_back(32'hFFFF8001);
      issue("LH_slow", 1, 0, 3'b001, 32'h202, 0, 3, 1, 32'h80010000, 6, 0, 0);

      bus_q.push_back('{1'b0, 4'b0011, 32'h0, 32'h0});
      ld_q.push_back(32'h00008001);
      issue("LHU", 1, 0, 3'b101, 32'h000, 0, 0, 0, 32'h12348001, 2, 0, 0);

      bus_q.push_back('{1'b1, 4'b1100, 32'h4, 32'hBEEFBEEF});
      issue("SH", 0, 1, 3'b001, 32'h006, 32'h1234BEEF, 1, 0, 0, 2, 0, 0);

      issue("LW_misaligned", 1, 0, 3'b010, 32'h105, 0, 0, 0, 0, 0, 1, 0);
      issue("LH_misaligned", 1, 0, 3'b001, 32'h101, 0, 0, 0, 0, 0, 1, 0);
      issue("ill_f3_011", 1, 0, 3'b011, 32'h100, 0, 0, 0, 0, 0, 0, 1);
      issue("ill_store_bu", 0, 1, 3'b100, 32'h100, 0, 0, 0, 0, 0, 0, 1);
      issue("ill_ld_and_st", 1, 1, 3'b010, 32'h100, 0, 0, 0, 0, 0, 0, 1);

      bus_q.push_back('{1'b1, 4'b1111, 32'h40, 32'h11223344});
      bus_q.push_back('{1'b0, 4'b1111, 32'h40, 32'h0});
      ld_q.push_back(32'h55667788);
      issue("b2b_SW", 0, 1, 3'b010, 32'h40, 32'h11223344, 0, 0, 0, 1, 0, 0);
      issue("b2b_LW", 1, 0, 3'b010, 32'h40, 0, 0, 0, 32'h55667788, 2, 0, 0);

      // Reset while a load waits for rvalid; the late rvalid must be ignored.
      gnt_delay = 0; rv_delay = 3; rdata_cfg = 32'hCAFEF00D;
      bus_q.push_back('{1'b0, 4'b1111, 32'h300, 32'h0});
      i_valid = 1'b1; i_load = 1'b1; i_store = 1'b0; i_funct3 = 3'b010; i_addr = 32'h300;
      @(posedge i_clk);
      @(posedge i_clk); #3;
      chk("wait_stall_before_rst", {31'd0, o_stall}, 32'd1);
      i_rst_n = 1'b0; #1;
      chk("rst_wait_stall", {31'd0, o_stall}, 32'd0);
      chk("rst_wait_req", {31'd0, o_dmem_req}, 32'd0);
      i_valid = 1'b0; i_load = 1'b0;
      i_rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge i_clk);
         chk("late_rvalid_ignored", {31'd0, o_ldValid}, 32'd0);
      end

      // Reset while a store sits in REQ: req drops without a clock edge.
      gnt_delay = 10;
      @(posedge i_clk); #1;
      i_valid = 1'b1; i_store = 1'b1; i_funct3 = 3'b010; i_addr = 32'h400; i_wdata = 32'h1;
      @(posedge i_clk);
      @(posedge i_clk); #3;
      chk("req_before_rst", {31'd0, o_dmem_req}, 32'd1);
      i_rst_n = 1'b0; #1;
      chk("rst_req_async", {31'd0, o_dmem_req}, 32'd0);
      chk("rst_req_stall", {31'd0, o_stall}, 32'd0);
      i_valid = 1'b0; i_store = 1'b0;
      i_rst_n = 1'b1;
      repeat (4) @(posedge i_clk);
      #1;
      chk("bus_queue_drained", bus_q.size(), 32'd0);
      chk("ld_queue_drained", ld_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
